multicycle_ctrl_fsm: RTL
========================

// Module: multicycle_ctrl_fsm
// PURPOSE
//  Main control FSM of the 16-bit multi-cycle processor. Sequences each instruction
//  through FETCH/DECODE/EXEC/MEM/WB and is the sole driver of the PC update strobe
//  (pc_write) and next-PC select. Also drives IR, memory, ALU and register-file controls.
//  Memory accesses use a req/ready handshake; a watchdog detects a hung bus.
// PARAMETERS
//  OPW          4    opcode width, taken from instr[15:12]
//  MEM_TIMEOUT  16   max cycles waiting for mem_ready before bus error (>=2)
//  CNTW         16   width of retired-instruction counter
// PORTS
//  clk          in   1     system clock, rising edge
//  proc_rst     in   1     reset, asynchronous, active-high
//  run          in   1     level; leaves IDLE when 1
//  opcode       in   OPW   IR[15:12], valid from DECODE onward
//  alu_zero     in   1     ALU zero flag, valid in EXEC
//  mem_ready    in   1     memory completes current request this cycle
//  mem_req      out  1     memory request, held until mem_ready
//  mem_we       out  1     write qualifier for mem_req (SW only)
//  iord         out  1     0: address=PC (fetch), 1: address=ALU result (data)
//  ir_write     out  1     load IR (one-cycle pulse)
//  pc_write     out  1     PC update strobe (one-cycle pulse)
//  pc_src       out  2     00 PC+1, 01 branch target, 10 jump target
//  alu_op       out  3     000 ADD, 001 SUB, 010 AND, 011 OR
//  alu_src_b    out  1     0 register, 1 sign-extended immediate
//  reg_write    out  1     register-file write (one-cycle pulse)
//  wb_sel       out  1     0 ALU result, 1 memory data
//  halted       out  1     FSM in HALT
//  bus_err      out  1     sticky; memory timeout occurred
//  illegal_op   out  1     one-cycle pulse on undefined opcode
//  instr_count  out  CNTW  retired instructions, wraps
// BEHAVIOUR
//  Reset: state=IDLE. All outputs 0, including instr_count and bus_err.
//  Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 ADDI, 5 LW, 6 SW, 7 BEQ, 8 JMP, F HLT.
//   Others are illegal.
//  IDLE:   run=1 -> FETCH.
//  FETCH:  mem_req=1, iord=0. Wait for mem_ready.
//   On mem_ready: ir_write=1, pc_write=1, pc_src=00 in the same cycle -> DECODE.
//  DECODE: 1 cycle.
//   HLT -> HALT.
//   illegal -> illegal_op=1 -> FETCH (retired as NOP).
//   else -> EXEC.
//  EXEC:   alu_op / alu_src_b per opcode. LW/SW/ADDI use alu_src_b=1 with ADD.
//   BEQ uses SUB.
//   R-type and ADDI -> WB.
//   LW/SW -> MEM.
//   BEQ: pc_write=alu_zero, pc_src=01 -> FETCH.
//   JMP: pc_write=1, pc_src=10 -> FETCH.
//  MEM:    mem_req=1, iord=1, mem_we=(SW). Wait for mem_ready.
//   LW -> WB (wb_sel=1).
//   SW -> FETCH.
//  WB:     reg_write=1 for 1 cycle, wb_sel=(LW) -> FETCH.
//  HALT:   halted=1. Absorbing state; only proc_rst exits.
//  Minimum latency (mem_ready tied 1):
//   R/ADDI 4 cycles, LW 5, SW 4, BEQ/JMP 3, illegal 2.
//  Handshake: mem_req and the address select are stable from assertion until mem_ready.
//   mem_ready while mem_req=0 is ignored.
//  Timeout: a wait counter clears on entering FETCH/MEM and counts cycles with
//   mem_req=1 and mem_ready=0. At MEM_TIMEOUT: bus_err=1, mem_req dropped next cycle,
//   -> HALT. mem_ready on the timeout cycle wins (no error).
//  instr_count += 1 on every transition into FETCH from DECODE/EXEC/MEM/WB.
//   Wraps at 2^CNTW-1 -> 0. HLT is not counted.
//  pc_write never asserts outside FETCH/EXEC. At most one pc_write per instruction,
//   except FETCH plus taken BEQ/JMP (two).
//  run deasserting mid-instruction has no effect; it is sampled only in IDLE.
//  proc_rst mid-handshake: outputs go to 0 immediately (async) and the request is abandoned.
// STRUCTURE
//  Package cpu16_ctrl_pkg:
//   - state enum (IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT)
//   - opcode constants
//   - PCSRC_* and ALUOP_* encodings
//  Sub-module mem_wait_timer: counter, clear/enable, timeout flag, parameter MEM_TIMEOUT.
//  Registered state; outputs decoded combinationally from state/opcode.
// TESTING
//  1. ADD with mem_ready=1: FETCH->DECODE->EXEC->WB->FETCH.
//     pc_write once (pc_src=00), reg_write once, instr_count 0->1.
//  2. LW with mem_ready delayed 3 cycles in FETCH and in MEM: mem_req held 4 cycles each,
//     iord 0 then 1, wb_sel=1 in WB, total 11 cycles.
//  3. BEQ with alu_zero=1 gives 2 pc_write pulses, second with pc_src=01.
//     BEQ with alu_zero=0 gives 1 pulse.
//     JMP gives a second pulse with pc_src=10.
//  4. Opcode 0xA: illegal_op pulses 1 cycle, back to FETCH, instr_count increments.
//     Opcode 0xF: halted=1 stays while run toggles.
//  5. mem_ready held 0 in MEM: bus_err=1 after 16 wait cycles, then HALT.
//     Repeat with mem_ready on cycle 16: no bus_err.
//  6. proc_rst asserted mid-MEM and mid-FETCH: all outputs 0 with no clock edge.
//     Run resumes from IDLE. Counter wrap at 0xFFFF -> 0x0000.

Source files
------------

// File: rtl/cpu16_ctrl_pkg.sv
// rtl/cpu16_ctrl_pkg.sv - shared encodings for the cpu16 control path
package cpu16_ctrl_pkg;

  // FSM state encoding
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_FETCH  = 3'd1;
  localparam state_t ST_DECODE = 3'd2;
  localparam state_t ST_EXEC   = 3'd3;
  localparam state_t ST_MEM    = 3'd4;
  localparam state_t ST_WB     = 3'd5;
  localparam state_t ST_HALT   = 3'd6;

  // Opcodes (IR[15:12])
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_ADDI = 4'h4;
  localparam logic [3:0] OP_LW   = 4'h5;
  localparam logic [3:0] OP_SW   = 4'h6;
  localparam logic [3:0] OP_BEQ  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_HLT  = 4'hF;

  // Next-PC select
  localparam logic [1:0] PCSRC_PC1    = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // ALU operation select
  localparam logic [2:0] ALUOP_ADD = 3'b000;
  localparam logic [2:0] ALUOP_SUB = 3'b001;
  localparam logic [2:0] ALUOP_AND = 3'b010;
  localparam logic [2:0] ALUOP_OR  = 3'b011;

  // Instruction classes that steer the sequencing
  typedef enum logic [2:0] {
    CLS_RTYPE,
    CLS_ADDI,
    CLS_LW,
    CLS_SW,
    CLS_BEQ,
    CLS_JMP,
    CLS_HLT,
    CLS_ILLEGAL
  } op_class_e;

  function automatic op_class_e classify(input logic [3:0] op);
    op_class_e cls;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: cls = CLS_RTYPE;
      OP_ADDI:                       cls = CLS_ADDI;
      OP_LW:                         cls = CLS_LW;
      OP_SW:                         cls = CLS_SW;
      OP_BEQ:                        cls = CLS_BEQ;
      OP_JMP:                        cls = CLS_JMP;
      OP_HLT:                        cls = CLS_HLT;
      default:                       cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

  // Address arithmetic (ADDI/LW/SW) is an add; BEQ compares by subtracting
  function automatic logic [2:0] alu_op_for(input logic [3:0] op);
    logic [2:0] aop;
    case (op)
      OP_SUB, OP_BEQ: aop = ALUOP_SUB;
      OP_AND:         aop = ALUOP_AND;
      OP_OR:          aop = ALUOP_OR;
      default:        aop = ALUOP_ADD;
    endcase
    return aop;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - counts unanswered memory-request cycles and flags a hung bus
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic proc_rst,
  input  logic clear,
  input  logic enable,
  output logic timeout
);

  localparam int CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

  logic [CW-1:0] count;

  // Timeout fires on the MEM_TIMEOUT-th waiting cycle; a ready in that cycle
  // drops enable, so the completing handshake wins over the error.
  assign timeout = enable && (count == CW'(MEM_TIMEOUT - 1));

  // Waiting-cycle counter; cleared whenever no request is outstanding
  always_ff @(posedge clk or posedge proc_rst) begin
    if (proc_rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !timeout) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// rtl/multicycle_ctrl_fsm.sv - main control FSM of the 16-bit multi-cycle processor
module multicycle_ctrl_fsm
  import cpu16_ctrl_pkg::*;
#(
  parameter int OPW         = 4,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNTW        = 16
) (
  input  logic            clk,
  input  logic            proc_rst,
  input  logic            run,
  input  logic [OPW-1:0]  opcode,
  input  logic            alu_zero,
  input  logic            mem_ready,
  output logic            mem_req,
  output logic            mem_we,
  output logic            iord,
  output logic            ir_write,
  output logic            pc_write,
  output logic [1:0]      pc_src,
  output logic [2:0]      alu_op,
  output logic            alu_src_b,
  output logic            reg_write,
  output logic            wb_sel,
  output logic            halted,
  output logic            bus_err,
  output logic            illegal_op,
  output logic [CNTW-1:0] instr_count
);

  state_t    state;
  state_t    state_nxt;
  op_class_e op_class;
  logic      retire;
  logic      wait_active;
  logic      mem_timeout;

  assign op_class = classify(opcode[3:0]);

  // A request is outstanding in exactly these two states
  assign wait_active = (state == ST_FETCH) || (state == ST_MEM);

  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_wait_timer (
    .clk      (clk),
    .proc_rst (proc_rst),
    .clear    (!wait_active || mem_ready),
    .enable   (wait_active && !mem_ready),
    .timeout  (mem_timeout)
  );

  // Next-state selection; retire marks every return to FETCH that ends an instruction
  always_comb begin
    state_nxt = state;
    retire    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (run) state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        if (mem_ready)        state_nxt = ST_DECODE;
        else if (mem_timeout) state_nxt = ST_HALT;
      end
      ST_DECODE: begin
        case (op_class)
          CLS_HLT:     state_nxt = ST_HALT;
          CLS_ILLEGAL: begin
            state_nxt = ST_FETCH;
            retire    = 1'b1;
          end
          default:     state_nxt = ST_EXEC;
        endcase
      end
      ST_EXEC: begin
        case (op_class)
          CLS_RTYPE, CLS_ADDI: state_nxt = ST_WB;
          CLS_LW, CLS_SW:      state_nxt = ST_MEM;
          default: begin
            state_nxt = ST_FETCH;
            retire    = 1'b1;
          end
        endcase
      end
      ST_MEM: begin
        if (mem_ready) begin
          if (op_class == CLS_LW) begin
            state_nxt = ST_WB;
          end else begin
            state_nxt = ST_FETCH;
            retire    = 1'b1;
          end
        end else if (mem_timeout) begin
          state_nxt = ST_HALT;
        end
      end
      ST_WB: begin
        state_nxt = ST_FETCH;
        retire    = 1'b1;
      end
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register, sticky bus error and retired-instruction counter
  always_ff @(posedge clk or posedge proc_rst) begin
    if (proc_rst) begin
      state       <= ST_IDLE;
      bus_err     <= 1'b0;
      instr_count <= '0;
    end else begin
      state <= state_nxt;
      if (mem_timeout) bus_err <= 1'b1;
      if (retire)      instr_count <= instr_count + 1'b1;
    end
  end

  // Datapath controls decoded from the current state and opcode
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PCSRC_PC1;
    alu_op     = ALUOP_ADD;
    alu_src_b  = 1'b0;
    reg_write  = 1'b0;
    wb_sel     = 1'b0;
    halted     = 1'b0;
    illegal_op = 1'b0;
    case (state)
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          pc_src   = PCSRC_PC1;
        end
      end
      ST_DECODE: begin
        illegal_op = (op_class == CLS_ILLEGAL);
      end
      ST_EXEC: begin
        alu_op    = alu_op_for(opcode[3:0]);
        alu_src_b = (op_class == CLS_ADDI) || (op_class == CLS_LW) || (op_class == CLS_SW);
        if (op_class == CLS_BEQ) begin
          pc_write = alu_zero;
          pc_src   = PCSRC_BRANCH;
        end else if (op_class == CLS_JMP) begin
          pc_write = 1'b1;
          pc_src   = PCSRC_JUMP;
        end
      end
      ST_MEM: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = (op_class == CLS_SW);
      end
      ST_WB: begin
        reg_write = 1'b1;
        wb_sel    = (op_class == CLS_LW);
      end
      ST_HALT: begin
        halted = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
